// File: rtl/csc_coef_ctl.sv
// csc_coef_ctl
//   Coefficient bank controller for the 3x3 colour-space-conversion datapath.
//   A shadow bank is written over a simple config port; a COMMIT request copies
//   it into the active bank that drives csc A00..A22. The copy happens only on a
//   frame boundary, found by snooping the csc x0 stream handshake, so a frame is
//   never converted with a mix of old and new coefficients.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active high
//   cfg_we     : config write strobe
//   cfg_addr   : 0..8 coef A{r}{c} at 3r+c, 9 = COMMIT, 10..15 no-op
//   cfg_wdata  : coefficient write data
//   cfg_rdata  : shadow coef at cfg_addr (combinational), 0 for addr >= 9
//   cfg_busy   : commit pending; config writes are dropped while high
//   x0_mflags  : snooped master flags [0]=valid [1]=sop [2]=eop [3]=unused
//   x0_sflags  : snooped slave flags  [0]=stall [1]=unused
//   coef       : active bank, A{r}{c} = coef[(3r+c)*W +: W]
//   swap       : one-cycle pulse after the active bank was updated
//   in_frame   : high between the sop beat and the eop beat
//   frame_cnt  : number of eop beats, wrapping
//   proto_err  : sticky, sop beat seen while already in a frame
module csc_coef_ctl #(
  parameter int unsigned W     = 16,
  parameter int unsigned UNITY = 1 << (W - 2),
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [W-1:0]     cfg_wdata,
  output logic [W-1:0]     cfg_rdata,
  output logic             cfg_busy,
  input  logic [3:0]       x0_mflags,
  input  logic [1:0]       x0_sflags,
  output logic [9*W-1:0]   coef,
  output logic             swap,
  output logic             in_frame,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             proto_err
);

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_shadow [9];
  logic [W-1:0]     r_active [9];
  logic             r_busy;
  logic             r_swap;
  logic             r_in_frame;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_proto_err;

  logic w_beat;
  logic w_sop_b;
  logic w_eop_b;
  logic w_safe;
  logic w_commit;
  logic w_unused;

  assign w_beat   = x0_mflags[0] & ~x0_sflags[0];
  assign w_sop_b  = w_beat & x0_mflags[1];
  assign w_eop_b  = w_beat & x0_mflags[2];
  // Safe to swap at the closing edge of a frame, or when no frame is open and
  // none is starting this cycle (a starting frame must keep the old bank).
  assign w_safe   = w_eop_b | (~r_in_frame & ~w_sop_b);
  assign w_commit = cfg_we & (cfg_addr == 4'd9);
  assign w_unused = ^{x0_mflags[3], x0_sflags[1]};

  // Identity matrix: diagonal entries sit at flat indices 0, 4 and 8.
  function automatic logic [W-1:0] ident(input int unsigned idx);
    return ((idx % 4) == 0) ? W'(UNITY) : '0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_swap      <= 1'b0;
      r_in_frame  <= 1'b0;
      r_frame_cnt <= '0;
      r_proto_err <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) begin
        r_shadow[i] <= ident(i);
        r_active[i] <= ident(i);
      end
    end else begin
      r_swap <= 1'b0;

      // Frame tracking; eop wins over sop so a single-beat frame leaves in_frame low.
      if (w_eop_b) begin
        r_in_frame  <= 1'b0;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end else if (w_sop_b) begin
        r_in_frame <= 1'b1;
      end
      if (w_sop_b && r_in_frame) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          for (int unsigned i = 0; i < 9; i++) begin
            if (cfg_we && (cfg_addr == 4'(i))) begin
              r_shadow[i] <= cfg_wdata;
            end
          end
          if (w_commit) begin
            r_state <= S_PEND;
            r_busy  <= 1'b1;
          end
        end
        S_PEND: begin
          if (w_safe) begin
            for (int unsigned i = 0; i < 9; i++) begin
              r_active[i] <= r_shadow[i];
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_swap  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (cfg_addr == 4'(i)) begin
        cfg_rdata = r_shadow[i];
      end
    end
  end

  always_comb begin
    coef = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      coef[i*W +: W] = r_active[i];
    end
  end

  assign cfg_busy  = r_busy;
  assign swap      = r_swap;
  assign in_frame  = r_in_frame;
  assign frame_cnt = r_frame_cnt;
  assign proto_err = r_proto_err;

endmodule
